// File: rtl/fir_pkg.sv
// Shared widths, Q1.15 sample/accumulator types and the output shift-and-saturate helper.
// Pure definitions: no latency and no flow control.
package fir_pkg;

  localparam int FIR_NTAPS = 204;
  localparam int FIR_DW    = 16;
  localparam int FIR_AW    = 8;
  localparam int FIR_ACC_W = 40;

  typedef logic signed [FIR_DW-1:0]    sample_t;
  typedef logic signed [FIR_ACC_W-1:0] acc_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(FIR_DW-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(FIR_DW-1){1'b0}}};

  // Q2.30 sum back to Q1.15: arithmetic shift floors toward -inf, then clamp.
  function automatic sample_t sat_q15(input acc_t s);
    acc_t q;
    q = s >>> (FIR_DW - 1);
    if (q > acc_t'(SAMPLE_MAX)) begin
      return SAMPLE_MAX;
    end else if (q < acc_t'(SAMPLE_MIN)) begin
      return SAMPLE_MIN;
    end else begin
      return q[FIR_DW-1:0];
    end
  endfunction

endpackage

// File: rtl/fir_broadcast_q15_if.sv
// Sample stream, datapath enable and coefficient write port of the broadcast FIR.
// One sample per enabled cycle; no handshake, the master stalls the filter via en.
interface fir_broadcast_q15_if #(
  parameter int DW = 16,
  parameter int AW = 8
);

  logic                 en;
  logic signed [DW-1:0] data_in;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [DW-1:0] coef_data;
  logic signed [DW-1:0] data_out;

  modport master (
    output en,
    output data_in,
    output coef_we,
    output coef_addr,
    output coef_data,
    input  data_out
  );

  modport slave (
    input  en,
    input  data_in,
    input  coef_we,
    input  coef_addr,
    input  coef_data,
    output data_out
  );

endinterface

// File: rtl/fir_tap.sv
// One transposed-form stage: z <= z_next_stage + coef * sample, held while en is low.
// Latency one enabled cycle; no backpressure beyond the shared enable.
module fir_tap
  import fir_pkg::*;
#(
  parameter int DW    = FIR_DW,
  parameter int ACC_W = FIR_ACC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic signed [DW-1:0]    coef_i,
  input  logic signed [DW-1:0]    sample_i,
  input  logic signed [ACC_W-1:0] z_i,
  output logic signed [ACC_W-1:0] z_o
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] z_d;
  logic signed [ACC_W-1:0] z_q;

  assign prod = coef_i * sample_i;
  assign z_d  = z_i + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_q <= '0;
    end else if (en_i) begin
      z_q <= z_d;
    end
  end

  assign z_o = z_q;

endmodule

// File: rtl/fir_broadcast_q15.sv
// Transposed-form Q1.15 FIR with a writable coefficient bank; y[n] = sum c[k]*x[n-k].
// Output registered one enabled cycle after the sample; en=0 freezes the chain and output.
module fir_broadcast_q15
  import fir_pkg::*;
#(
  parameter int NTAPS = FIR_NTAPS,
  parameter int DW    = FIR_DW,
  parameter int AW    = FIR_AW,
  parameter int ACC_W = FIR_ACC_W
) (
  input  logic                clk,
  input  logic                reset,
  fir_broadcast_q15_if.slave  bus
);

  logic signed [DW-1:0]    coef_q [NTAPS];
  logic signed [ACC_W-1:0] z_chain [1:NTAPS];
  logic signed [2*DW-1:0]  p0;
  logic signed [ACC_W-1:0] s0;
  logic signed [DW-1:0]    data_out_d;
  logic signed [DW-1:0]    data_out_q;

  // Addresses at or beyond NTAPS match no entry, so such writes fall through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        coef_q[k] <= '0;
      end
    end else if (bus.coef_we) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (bus.coef_addr == AW'(k)) begin
          coef_q[k] <= bus.coef_data;
        end
      end
    end
  end

  assign z_chain[NTAPS] = '0;

  for (genvar k = 1; k < NTAPS; k++) begin : g_tap
    fir_tap #(
      .DW    (DW),
      .ACC_W (ACC_W)
    ) u_tap (
      .clk      (clk),
      .reset    (reset),
      .en_i     (bus.en),
      .coef_i   (coef_q[k]),
      .sample_i (bus.data_in),
      .z_i      (z_chain[k+1]),
      .z_o      (z_chain[k])
    );
  end

  assign p0         = coef_q[0] * bus.data_in;
  assign s0         = z_chain[1] + {{(ACC_W-2*DW){p0[2*DW-1]}}, p0};
  assign data_out_d = sat_q15(acc_t'(s0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q <= '0;
    end else if (bus.en) begin
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_fir_broadcast_q15.sv
// Directed bench for fir_broadcast_q15: impulse, enable hold, async reset,
// saturation and coefficient-write cases against hand-computed Q1.15 outputs.
module tb_fir_broadcast_q15;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fir_broadcast_q15_if #(.DW(16), .AW(8)) bus ();

  fir_broadcast_q15 #(
    .NTAPS (204),
    .DW    (16),
    .AW    (8),
    .ACC_W (40)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, want 0x%04h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en      = 1'b0;
    bus.data_in = 16'h0000;
    bus.coef_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    reset = 1'b1;
  endtask

  task automatic wr(input int addr, input logic [15:0] val);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 8'(addr);
    bus.coef_data = val;
    step();
    bus.coef_we   = 1'b0;
  endtask

  task automatic load_impulse();
    do_reset();
    idle();
    wr(0, 16'h4000);
    wr(1, 16'h2000);
    wr(203, 16'h7FFF);
    wr(210, 16'h7FFF);
  endtask

  task automatic run_zeros(input int n, input string tag);
    logic [15:0] first_bad;
    first_bad = 16'h0000;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.data_out !== 16'h0000 && first_bad == 16'h0000) first_bad = bus.data_out;
    end
    chk(tag, first_bad, 16'h0000);
  endtask

  // Remainder of the impulse response after the 0x3FFF output, en held high.
  task automatic impulse_tail(input string pfx);
    bus.en      = 1'b1;
    bus.data_in = 16'h0000;
    step();
    chk({pfx, "_c1"}, bus.data_out, 16'h1FFF);
    run_zeros(201, {pfx, "_zeros"});
    step();
    chk({pfx, "_c203"}, bus.data_out, 16'h7FFE);
    step();
    chk({pfx, "_after"}, bus.data_out, 16'h0000);
  endtask

  task automatic sat_run(input logic [15:0] x, input logic [15:0] first,
                         input logic [15:0] rail, input string pfx);
    do_reset();
    idle();
    for (int k = 0; k < 204; k++) wr(k, 16'h7FFF);
    bus.en      = 1'b1;
    bus.data_in = x;
    step();
    chk({pfx, "_e1"}, bus.data_out, first);
    step();
    chk({pfx, "_e2"}, bus.data_out, rail);
    for (int i = 0; i < 210; i++) step();
    chk({pfx, "_long"}, bus.data_out, rail);
  endtask

  initial begin
    reset         = 1'b1;
    bus.coef_addr = 8'h00;
    bus.coef_data = 16'h0000;
    idle();
    #1 reset = 1'b0;
    #1 chk("reset_out", bus.data_out, 16'h0000);
    #1 reset = 1'b1;
    step();

    // Impulse response, including an ignored write to address 210.
    load_impulse();
    bus.en      = 1'b1;
    bus.data_in = 16'h7FFF;
    step();
    chk("imp_c0", bus.data_out, 16'h3FFF);
    impulse_tail("imp");

    // Enable dropped for 5 cycles after the first output; input must be ignored.
    load_impulse();
    bus.en      = 1'b1;
    bus.data_in = 16'h7FFF;
    step();
    chk("hold_c0", bus.data_out, 16'h3FFF);
    bus.en      = 1'b0;
    bus.data_in = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_idle", bus.data_out, 16'h3FFF);
    end
    impulse_tail("hold");

    // Async reset mid-stream: 0x7FFF gives 0x3FFF then (0x4000+0x2000)*x -> 0x5FFF.
    bus.en      = 1'b1;
    bus.data_in = 16'h7FFF;
    step();
    chk("stream_e1", bus.data_out, 16'h3FFF);
    step();
    chk("stream_e2", bus.data_out, 16'h5FFF);
    #2 reset = 1'b0;
    #1 chk("arst_now", bus.data_out, 16'h0000);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst", bus.data_out, 16'h0000);
    end

    sat_run(16'h7FFF, 16'h7FFE, 16'h7FFF, "sat_pos");
    sat_run(16'h8000, 16'h8001, 16'h8000, "sat_neg");

    // c[0] rewritten while streaming: old value still used on the write edge.
    do_reset();
    idle();
    wr(0, 16'h4000);
    bus.en      = 1'b1;
    bus.data_in = 16'h7FFF;
    step();
    chk("cw_pre", bus.data_out, 16'h3FFF);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 8'd0;
    bus.coef_data = 16'hC000;
    step();
    bus.coef_we   = 1'b0;
    chk("cw_edge", bus.data_out, 16'h3FFF);
    step();
    chk("cw_new", bus.data_out, 16'hC000);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 8'd210;
    bus.coef_data = 16'h7FFF;
    step();
    bus.coef_we   = 1'b0;
    chk("cw_210a", bus.data_out, 16'hC000);
    step();
    chk("cw_210b", bus.data_out, 16'hC000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
